ram512_arbiter: RTL
===================

RAM512_ARBITER -- requirements
Module: ram512_arbiter

Interface
REQ-001 The parameter list SHALL be fixed as localparams: WIDTH, 16, data word width.
REQ-002 The parameter list SHALL be fixed as localparams: AW, 9, address width, matching the 512-word RAM.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock shared with the RAM
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  requester A transaction valid; held with payload until a_ack
- a_we  in  1  A: 1=write, 0=read
- a_addr  in  9  A word address
- a_wdata  in  16  A write data
- a_ack  out  1  A request accepted this cycle
- a_done  out  1  one-cycle pulse, A transaction complete
- a_rdata  out  16  A read data, valid from a_done until A's next read done
- b_req, b_we, b_addr, b_wdata, b_ack, b_done, b_rdata  SHALL mirror A for requester B
- ram_load  out  1  RAM write enable
- ram_address  out  9  RAM address
- ram_in  out  16  RAM write data
- ram_out  in  16  RAM read data; combinational from ram_address

Function
REQ-005 FSM states SHALL be IDLE and ACCESS; IDLE->ACCESS when any req=1 in IDLE; ACCESS->IDLE unconditionally.
REQ-006 In IDLE with exactly one req high, that requester SHALL be granted: x_ack=1 combinationally in the same cycle.
REQ-007 In IDLE with both reqs high, the requester selected by a 1-bit round-robin pointer SHALL be granted; the pointer SHALL flip to the other requester after every grant.
REQ-008 x_ack SHALL be 0 in ACCESS, and 0 for a requester that is not granted.
REQ-009 At the grant edge, the winner's we, addr and wdata SHALL be captured into ram_load, ram_address and ram_in registers; an owner flag records A or B.
REQ-010 ram_load SHALL be 1 only during the ACCESS cycle of a write; the RAM commits the write at the ACCESS-ending edge.
REQ-011 For a read, ram_out SHALL be sampled at the ACCESS-ending edge into the owner's x_rdata.
REQ-012 For a write, x_rdata SHALL be left unchanged.
REQ-013 x_done SHALL pulse for exactly the cycle after ACCESS, for reads and writes alike.
REQ-014 Latency: req/ack in cycle T, RAM access in T+1, done in T+2.
REQ-015 A new grant MAY occur in T+2, coincident with done, giving a throughput of 1 transaction per 2 cycles.
REQ-016 ram_address and ram_in SHALL hold their last captured values while in IDLE.
REQ-017 Dropping req in IDLE before ack SHALL cause no capture and no side effect.
REQ-018 Payload changes after ack SHALL be ignored.
REQ-019 A write followed by a read of the same address (any requesters) SHALL return the written data.
REQ-020 A single requester asserting req continuously SHALL be served every 2 cycles.
REQ-021 With both requesters asserting continuously, grants SHALL strictly alternate A,B,A,B.

Reset
REQ-022 On rst_n=0, immediately and regardless of state: FSM=IDLE, pointer favours A; ram_load, ram_address, ram_in, a_rdata, b_rdata, owner = 0; a_ack, b_ack, a_done, b_done = 0.
REQ-023 Reset during ACCESS SHALL abort the transaction: no done pulse, ram_load deasserted immediately; a write in flight is not guaranteed committed.
REQ-024 Operation SHALL resume on the first rising clk edge after rst_n returns to 1.

Verification
REQ-025 A write addr 0x1FF data 0xBEEF, then A read 0x1FF -> a_ack at T, ram_load=1 at T+1, a_done at T+2; the read's a_done is accompanied by a_rdata=0xBEEF.
REQ-026 A and B both request in the same cycle after reset -> A acked first, B acked in the next IDLE cycle; b_done 2 cycles after a_done.
REQ-027 Both requesters continuously request reads of 0x000 and 0x040 -> grant order A,B,A,B for 8 grants; each requester's rdata matches its address's preloaded value.
REQ-028 B write 0x123=0x5A5A, then A read 0x123 -> a_rdata=0x5A5A; b_rdata unchanged.
REQ-029 rst_n pulsed low during ACCESS of an A read -> a_done never pulses, all outputs 0 asynchronously, next A request served normally.
REQ-030 A req pulses for 1 cycle while the FSM is in ACCESS (no ack) -> no transaction, no done pulse, RAM contents unchanged.

Source files
------------

// File: rtl/ram512_arbiter.sv
// rtl/ram512_arbiter.sv - two-requester round-robin arbiter in front of a 512x16 single-port RAM
module ram512_arbiter #(
   localparam int WIDTH = 16,
   localparam int AW    = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_req,
   input  logic             a_we,
   input  logic [AW-1:0]    a_addr,
   input  logic [WIDTH-1:0] a_wdata,
   output logic             a_ack,
   output logic             a_done,
   output logic [WIDTH-1:0] a_rdata,
   input  logic             b_req,
   input  logic             b_we,
   input  logic [AW-1:0]    b_addr,
   input  logic [WIDTH-1:0] b_wdata,
   output logic             b_ack,
   output logic             b_done,
   output logic [WIDTH-1:0] b_rdata,
   output logic             ram_load,
   output logic [AW-1:0]    ram_address,
   output logic [WIDTH-1:0] ram_in,
   input  logic [WIDTH-1:0] ram_out
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t state, state_nxt;
   logic   rr_ptr;   // 0 favours A, 1 favours B on a tie
   logic   owner;    // 0 = A owns the access in flight, 1 = B
   logic   grant_a, grant_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (a_req || b_req) state_nxt = ACCESS;
         ACCESS:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Acks are gated by rst_n so they read 0 for the whole reset pulse.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state == IDLE && rst_n) begin
         if (a_req && (!b_req || !rr_ptr)) grant_a = 1'b1;
         else if (b_req)                   grant_b = 1'b1;
      end
      a_ack = grant_a;
      b_ack = grant_b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr      <= 1'b0;
         owner       <= 1'b0;
         ram_load    <= 1'b0;
         ram_address <= '0;
         ram_in      <= '0;
         a_rdata     <= '0;
         b_rdata     <= '0;
         a_done      <= 1'b0;
         b_done      <= 1'b0;
      end else begin
         a_done <= 1'b0;
         b_done <= 1'b0;
         if (state == IDLE) begin
            if (grant_a) begin
               ram_load    <= a_we;
               ram_address <= a_addr;
               ram_in      <= a_wdata;
               owner       <= 1'b0;
               rr_ptr      <= 1'b1;
            end else if (grant_b) begin
               ram_load    <= b_we;
               ram_address <= b_addr;
               ram_in      <= b_wdata;
               owner       <= 1'b1;
               rr_ptr      <= 1'b0;
            end
         end else begin
            // ACCESS-ending edge: RAM commits any write, reads are sampled here.
            ram_load <= 1'b0;
            if (!owner) begin
               a_done <= 1'b1;
               if (!ram_load) a_rdata <= ram_out;
            end else begin
               b_done <= 1'b1;
               if (!ram_load) b_rdata <= ram_out;
            end
         end
      end
   end

endmodule
